// File: rtl/morse_decoder_if.sv
// Character output channel of the Morse decoder: decoded character plus a
// valid/ack handshake and status flags. The decoder drives it as master.
interface morse_decoder_if;
  logic       char_ack;
  logic [7:0] charcode_data;
  logic [3:0] charlen_data;
  logic       char_valid;
  logic       char_err;
  logic       overrun;

  modport master (
    input  char_ack,
    output charcode_data,
    output charlen_data,
    output char_valid,
    output char_err,
    output overrun
  );

  modport slave (
    output char_ack,
    input  charcode_data,
    input  charlen_data,
    input  char_valid,
    input  char_err,
    input  overrun
  );
endinterface

// File: rtl/morse_decoder.sv
// Decodes a keyed Morse line into characters (dot/dash bit patterns) and word
// spaces, presented one at a time through a valid/ack output register.
module morse_decoder #(
  parameter int unsigned UNIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            key_in,
  morse_decoder_if.master char_bus
);

  localparam logic [7:0] CHAR_GAP = 8'(2 * UNIT);
  localparam logic [7:0] WORD_GAP = 8'(5 * UNIT);

  typedef enum logic [1:0] {IDLE, MARK, GAP, WGAP} state_t;

  state_t     state, state_next;
  logic       key_meta, key_s;
  logic [7:0] run_cnt, run_cnt_next, run_cnt_inc;
  logic [7:0] code, code_next;
  logic [3:0] len, len_next;
  logic       err, err_next;
  logic       is_dash;

  logic       emit;
  logic [7:0] emit_code;
  logic [3:0] emit_len;
  logic       emit_err;

  logic [7:0] out_code;
  logic [3:0] out_len;
  logic       out_err;
  logic       out_valid;
  logic       out_overrun;
  logic       ack_fire;

  assign run_cnt_inc = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
  assign is_dash     = (run_cnt >= CHAR_GAP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      run_cnt <= 8'd0;
      code    <= 8'd0;
      len     <= 4'd0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      run_cnt <= run_cnt_next;
      code    <= code_next;
      len     <= len_next;
      err     <= err_next;
    end
  end

  // The character-gap threshold wins over a returning mark, so a gap of
  // exactly 2*UNIT cycles always terminates the character.
  always_comb begin
    state_next   = state;
    run_cnt_next = run_cnt;
    code_next    = code;
    len_next     = len;
    err_next     = err;
    emit         = 1'b0;
    emit_code    = code;
    emit_len     = len;
    emit_err     = err;

    case (state)
      IDLE: begin
        if (key_s) begin
          state_next   = MARK;
          run_cnt_next = 8'd1;
        end
      end

      MARK: begin
        if (key_s) begin
          run_cnt_next = run_cnt_inc;
        end else begin
          if (len == 4'd8) begin
            err_next = 1'b1;
          end else begin
            code_next[3'd7 - len[2:0]] = is_dash;
            len_next                   = len + 4'd1;
          end
          state_next   = GAP;
          run_cnt_next = 8'd1;
        end
      end

      GAP: begin
        if (run_cnt >= CHAR_GAP) begin
          emit         = 1'b1;
          code_next    = 8'd0;
          len_next     = 4'd0;
          err_next     = 1'b0;
          state_next   = WGAP;
          run_cnt_next = run_cnt_inc;
        end else if (key_s) begin
          state_next   = MARK;
          run_cnt_next = 8'd1;
        end else begin
          run_cnt_next = run_cnt_inc;
        end
      end

      WGAP: begin
        if (key_s) begin
          state_next   = MARK;
          run_cnt_next = 8'd1;
        end else if (run_cnt >= WORD_GAP) begin
          emit         = 1'b1;
          emit_code    = 8'd0;
          emit_len     = 4'd0;
          emit_err     = 1'b0;
          state_next   = IDLE;
          run_cnt_next = 8'd0;
        end else begin
          run_cnt_next = run_cnt_inc;
        end
      end

      default: begin
        state_next   = IDLE;
        run_cnt_next = 8'd0;
      end
    endcase
  end

  assign ack_fire = char_bus.char_ack & out_valid;

  // An ack in the same cycle as an emit frees the slot, so the new
  // character replaces the old one without raising overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_code    <= 8'd0;
      out_len     <= 4'd0;
      out_err     <= 1'b0;
      out_valid   <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      if (emit) begin
        if (!out_valid || ack_fire) begin
          out_code  <= emit_code;
          out_len   <= emit_len;
          out_err   <= emit_err;
          out_valid <= 1'b1;
        end else begin
          out_overrun <= 1'b1;
        end
      end else if (ack_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign char_bus.charcode_data = out_code;
  assign char_bus.charlen_data  = out_len;
  assign char_bus.char_err      = out_err;
  assign char_bus.char_valid    = out_valid;
  assign char_bus.overrun       = out_overrun;

  a_len_bounded: assert property (@(posedge clock) disable iff (!reset)
    len <= 4'd8);
  a_out_len_bounded: assert property (@(posedge clock) disable iff (!reset)
    out_len <= 4'd8);

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder at UNIT=4: a table of keyed characters
// plus hand-timed sequences for latency, boundaries, overrun and reset.
module tb_morse_decoder;

  localparam int DOT_LEN  = 4;
  localparam int DASH_LEN = 12;
  localparam int ELEM_GAP = 4;

  logic clock;
  logic reset;
  logic key_in;

  int n_checks = 0;
  int n_fail   = 0;

  morse_decoder_if char_bus ();

  morse_decoder #(.UNIT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .key_in   (key_in),
    .char_bus (char_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // dash_mask bit i is element i (first keyed element in bit 0).
  typedef struct {
    int         n_elem;
    logic [9:0] dash_mask;
    logic [7:0] exp_code;
    logic [3:0] exp_len;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic key_run(input logic level, input int cycles);
    key_in = level;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic apply_stimulus(input int n_elem, input logic [9:0] dash_mask);
    for (int i = 0; i < n_elem; i++) begin
      key_run(1'b1, dash_mask[i] ? DASH_LEN : DOT_LEN);
      if (i < n_elem - 1) key_run(1'b0, ELEM_GAP);
    end
    key_in = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int cycles;
    cycles = 0;
    while (char_bus.char_valid !== 1'b1 && cycles < 300) begin
      @(negedge clock);
      cycles++;
    end
    if (char_bus.char_valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: char_valid timeout, got 0, expected 1", name);
    end
  endtask

  task automatic ack_char();
    char_bus.char_ack = 1'b1;
    @(negedge clock);
    char_bus.char_ack = 1'b0;
  endtask

  task automatic check_char(input string name, input logic [7:0] code,
                            input logic [3:0] len, input logic err);
    check_output({name, "_code"}, 32'(char_bus.charcode_data), 32'(code));
    check_output({name, "_len"},  32'(char_bus.charlen_data),  32'(len));
    check_output({name, "_err"},  32'(char_bus.char_err),      32'(err));
  endtask

  task automatic expect_word_space(input string name);
    wait_valid({name, "_space"});
    check_char({name, "_space"}, 8'h00, 4'd0, 1'b0);
    ack_char();
  endtask

  initial begin
    vecs[0] = '{1, 10'b0000000000, 8'h00, 4'd1, 1'b0};
    vecs[1] = '{1, 10'b0000000001, 8'h80, 4'd1, 1'b0};
    vecs[2] = '{2, 10'b0000000010, 8'h40, 4'd2, 1'b0};
    vecs[3] = '{2, 10'b0000000001, 8'h80, 4'd2, 1'b0};
    vecs[4] = '{3, 10'b0000000101, 8'hA0, 4'd3, 1'b0};
    vecs[5] = '{4, 10'b0000001011, 8'hD0, 4'd4, 1'b0};
    vecs[6] = '{5, 10'b0000011111, 8'hF8, 4'd5, 1'b0};
    vecs[7] = '{8, 10'b0001010101, 8'hAA, 4'd8, 1'b0};
    vecs[8] = '{9, 10'b0000000000, 8'h00, 4'd8, 1'b1};
    vecs[9] = '{9, 10'b0111111111, 8'hFF, 4'd8, 1'b1};

    reset             = 1'b0;
    key_in            = 1'b0;
    char_bus.char_ack = 1'b0;
    repeat (3) @(negedge clock);
    check_output("rst_code",    32'(char_bus.charcode_data), 32'h00);
    check_output("rst_len",     32'(char_bus.charlen_data),  32'h0);
    check_output("rst_valid",   32'(char_bus.char_valid),    32'h0);
    check_output("rst_err",     32'(char_bus.char_err),      32'h0);
    check_output("rst_overrun", 32'(char_bus.overrun),       32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // A stray ack with nothing pending must not disturb anything.
    ack_char();
    check_output("idle_ack_valid", 32'(char_bus.char_valid), 32'h0);

    for (int v = 0; v < 10; v++) begin
      apply_stimulus(vecs[v].n_elem, vecs[v].dash_mask);
      wait_valid($sformatf("vec%0d", v));
      check_char($sformatf("vec%0d", v), vecs[v].exp_code, vecs[v].exp_len,
                 vecs[v].exp_err);
      ack_char();
      check_output($sformatf("vec%0d_ack_drop", v), 32'(char_bus.char_valid), 32'h0);
      expect_word_space($sformatf("vec%0d", v));
    end

    // 'A': valid rises on the 11th negedge after key_in falls.
    apply_stimulus(2, 10'b0000000010);
    repeat (10) @(negedge clock);
    check_output("a_latency_early", 32'(char_bus.char_valid), 32'h0);
    @(negedge clock);
    check_output("a_latency", 32'(char_bus.char_valid), 32'h1);
    check_char("a", 8'h40, 4'd2, 1'b0);
    ack_char();
    expect_word_space("a");

    // Mark of 7 is a dot, mark of 8 a dash.
    key_run(1'b1, 7);
    key_run(1'b0, 4);
    key_run(1'b1, 8);
    key_in = 1'b0;
    wait_valid("mark_bnd");
    check_char("mark_bnd", 8'h40, 4'd2, 1'b0);
    ack_char();
    expect_word_space("mark_bnd");

    // Gap of 7 keeps the character together.
    key_run(1'b1, 4);
    key_run(1'b0, 7);
    key_run(1'b1, 12);
    key_in = 1'b0;
    wait_valid("gap7");
    check_char("gap7", 8'h40, 4'd2, 1'b0);
    ack_char();
    expect_word_space("gap7");

    // Gap of 8 splits it into E then T.
    key_run(1'b1, 4);
    key_run(1'b0, 8);
    key_run(1'b1, 12);
    key_in = 1'b0;
    wait_valid("gap8_first");
    check_char("gap8_first", 8'h00, 4'd1, 1'b0);
    ack_char();
    wait_valid("gap8_second");
    check_char("gap8_second", 8'h80, 4'd1, 1'b0);
    ack_char();
    expect_word_space("gap8");

    // E then T with no ack: E is held, T and the word space are dropped.
    key_run(1'b1, 4);
    key_run(1'b0, 8);
    key_run(1'b1, 12);
    key_run(1'b0, 30);
    check_output("noack_valid", 32'(char_bus.char_valid), 32'h1);
    check_char("noack", 8'h00, 4'd1, 1'b0);
    check_output("noack_overrun", 32'(char_bus.overrun), 32'h1);
    ack_char();
    check_output("noack_ack_valid", 32'(char_bus.char_valid), 32'h0);
    check_output("overrun_sticky", 32'(char_bus.overrun), 32'h1);

    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_output("rst2_overrun", 32'(char_bus.overrun), 32'h0);

    // E left pending, ack lands exactly in T's emit cycle.
    key_run(1'b1, 4);
    key_run(1'b0, 8);
    key_run(1'b1, 12);
    key_in = 1'b0;
    repeat (10) @(negedge clock);
    check_char("pre_emit", 8'h00, 4'd1, 1'b0);
    ack_char();
    check_output("emit_ack_valid", 32'(char_bus.char_valid), 32'h1);
    check_char("emit_ack", 8'h80, 4'd1, 1'b0);
    check_output("emit_ack_overrun", 32'(char_bus.overrun), 32'h0);
    repeat (20) @(negedge clock);
    check_output("space_overrun", 32'(char_bus.overrun), 32'h1);
    check_output("space_held_code", 32'(char_bus.charcode_data), 32'h80);

    // Reset in the middle of a dash discards it.
    key_run(1'b1, 6);
    reset = 1'b0;
    #1;
    check_output("async_rst_valid",   32'(char_bus.char_valid), 32'h0);
    check_output("async_rst_overrun", 32'(char_bus.overrun),    32'h0);
    repeat (3) @(negedge clock);
    key_in = 1'b0;
    reset  = 1'b1;
    repeat (30) @(negedge clock);
    check_output("middash_valid", 32'(char_bus.char_valid), 32'h0);
    check_char("middash", 8'h00, 4'd0, 1'b0);
    check_output("middash_overrun", 32'(char_bus.overrun), 32'h0);

    // Key held high across reset release is decoded from key_s's first 1.
    reset  = 1'b0;
    key_in = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    key_in = 1'b0;
    wait_valid("held_key");
    check_char("held_key", 8'h80, 4'd1, 1'b0);
    ack_char();
    expect_word_space("held_key");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
